// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the ID/EX pipeline register and
// the hazard/forwarding logic.
//   shift_sel_t    : shifter operation select (none, sll, srl, sra)
//   ex_ctrl_t      : control bundle carried from ID into EX
//   EX_CTRL_BUBBLE : all-zero control bundle; a bubble has no side effects
//                    and its shifter select is SH_NONE
package mips_pkg;

   localparam int unsigned EX_DATA_W     = 32;
   localparam int unsigned EX_REG_ADDR_W = 5;
   localparam int unsigned EX_ALU_CTRL_W = 4;

   typedef enum logic [1:0] {
      SH_NONE = 2'd0,
      SH_SLL  = 2'd1,
      SH_SRL  = 2'd2,
      SH_SRA  = 2'd3
   } shift_sel_t;

   typedef struct packed {
      logic [EX_ALU_CTRL_W-1:0] alu_ctrl;
      shift_sel_t               shifter_select;
      logic                     reg_write;
      logic                     mem_read;
      logic                     mem_write;
      logic                     mem_to_reg;
      logic [EX_REG_ADDR_W-1:0] dest_reg;
   } ex_ctrl_t;

   localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

   // Shift amount actually used by the shifter: the rs low bits for
   // variable shifts (sllv/srlv/srav), the instruction field otherwise.
   function automatic logic [$clog2(EX_DATA_W)-1:0] resolve_shamt(
      input logic                          shamt_var,
      input logic [EX_DATA_W-1:0]          rs_data,
      input logic [$clog2(EX_DATA_W)-1:0]  shamt_field
   );
      return shamt_var ? rs_data[$clog2(EX_DATA_W)-1:0] : shamt_field;
   endfunction

endpackage

// File: rtl/hazard_detect_lu.sv
// hazard_detect_lu: combinational load-use comparator.
// Raises hazard when the instruction in EX is a valid load writing a
// non-zero register that the valid instruction in ID reads as rs or rt.
// Ports:
//   ex_valid, ex_mem_read, ex_dest_reg : current EX-stage state
//   id_valid, id_rs_addr, id_rt_addr   : ID-stage source registers
//   hazard                             : load-use hazard flag
module hazard_detect_lu #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_dest_reg,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   output logic                  hazard
);

   logic dest_nonzero;
   logic src_match;

   // Register 0 is hard-wired, so a load targeting it never creates a dependency.
   assign dest_nonzero = (ex_dest_reg != '0);
   assign src_match    = (ex_dest_reg == id_rs_addr) || (ex_dest_reg == id_rt_addr);
   assign hazard       = ex_valid && ex_mem_read && dest_nonzero && id_valid && src_match;

endmodule

// File: rtl/id_ex_shift_reg.sv
// id_ex_shift_reg: ID/EX pipeline register feeding the execute stage and
// its shifter. Resolves the shift amount at capture time, handles stall
// and flush (flush wins), and flags load-use hazards.
// Optional build macro: ID_EX_PERF_EN adds stall_cnt / bubble_cnt.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   stall, flush        : hold EX / replace EX with a bubble
//   id_*                : decoded instruction from ID
//   ex_*                : registered EX-stage copies (1 cycle latency)
//   ex_shift_in         : shifter operand (registered rt data)
//   ex_shamt            : resolved shift amount
//   load_use_hazard     : combinational, to the hazard unit
//   stall_cnt/bubble_cnt: perf counters (ID_EX_PERF_EN only)
module id_ex_shift_reg
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W     = EX_DATA_W,
   parameter int unsigned REG_ADDR_W = EX_REG_ADDR_W,
   parameter int unsigned ALU_CTRL_W = EX_ALU_CTRL_W,
   parameter int unsigned SHAMT_W    = $clog2(DATA_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     id_pc,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [SHAMT_W-1:0]    id_shamt,
   input  logic                  id_shamt_var,
   input  logic [1:0]            id_shifter_select,
   input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
   input  logic [REG_ADDR_W-1:0] id_dest_reg,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_mem_to_reg,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_pc,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_shift_in,
   output logic [SHAMT_W-1:0]    ex_shamt,
   output logic [1:0]            ex_shifter_select,
   output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
   output logic [REG_ADDR_W-1:0] ex_dest_reg,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_mem_to_reg,
`ifdef ID_EX_PERF_EN
   output logic [31:0]           stall_cnt,
   output logic [31:0]           bubble_cnt,
`endif
   output logic                  load_use_hazard
);

   // ---------------------------------------------------------------
   // Pipeline registers
   // ---------------------------------------------------------------
   logic              valid_q;
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] rs_data_q;
   logic [DATA_W-1:0] rt_data_q;
   logic [DATA_W-1:0] imm_q;
   logic [SHAMT_W-1:0] shamt_q;
   ex_ctrl_t          ctrl_q;

   // Values written on a load edge. An invalid ID slot produces exactly
   // the bubble image, so flush and "load nothing" share one encoding.
   logic              valid_d;
   logic [DATA_W-1:0] pc_d;
   logic [DATA_W-1:0] rs_data_d;
   logic [DATA_W-1:0] rt_data_d;
   logic [DATA_W-1:0] imm_d;
   logic [SHAMT_W-1:0] shamt_d;
   ex_ctrl_t          ctrl_d;

   always_comb begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      shamt_d   = '0;
      ctrl_d    = EX_CTRL_BUBBLE;
      if (id_valid) begin
         valid_d               = 1'b1;
         pc_d                  = id_pc;
         rs_data_d             = id_rs_data;
         rt_data_d             = id_rt_data;
         imm_d                 = id_imm;
         // Resolved here so EX never needs the raw rs value for shifting.
         shamt_d               = resolve_shamt(id_shamt_var, id_rs_data, id_shamt);
         ctrl_d.alu_ctrl       = id_alu_ctrl;
         ctrl_d.shifter_select = shift_sel_t'(id_shifter_select);
         ctrl_d.reg_write      = id_reg_write;
         ctrl_d.mem_read       = id_mem_read;
         ctrl_d.mem_write      = id_mem_write;
         ctrl_d.mem_to_reg     = id_mem_to_reg;
         ctrl_d.dest_reg       = id_dest_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         shamt_q   <= '0;
         ctrl_q    <= EX_CTRL_BUBBLE;
      end else if (flush) begin
         // Flush overrides stall: a mispredict kill beats a hazard hold.
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         shamt_q   <= '0;
         ctrl_q    <= EX_CTRL_BUBBLE;
      end else if (!stall) begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         shamt_q   <= shamt_d;
         ctrl_q    <= ctrl_d;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign ex_valid          = valid_q;
   assign ex_pc             = pc_q;
   assign ex_rs_data        = rs_data_q;
   assign ex_rt_data        = rt_data_q;
   assign ex_imm            = imm_q;
   assign ex_shift_in       = rt_data_q;
   assign ex_shamt          = shamt_q;
   assign ex_shifter_select = ctrl_q.shifter_select;
   assign ex_alu_ctrl       = ctrl_q.alu_ctrl;
   assign ex_dest_reg       = ctrl_q.dest_reg;
   assign ex_reg_write      = ctrl_q.reg_write;
   assign ex_mem_read       = ctrl_q.mem_read;
   assign ex_mem_write      = ctrl_q.mem_write;
   assign ex_mem_to_reg     = ctrl_q.mem_to_reg;

   // Evaluated on the held EX contents, so it stays high for the whole stall.
   hazard_detect_lu #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect_lu (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_dest_reg (ctrl_q.dest_reg),
      .id_valid    (id_valid),
      .id_rs_addr  (id_rs_addr),
      .id_rt_addr  (id_rt_addr),
      .hazard      (load_use_hazard)
   );

`ifdef ID_EX_PERF_EN
   // ---------------------------------------------------------------
   // Performance counters (wrap modulo 2^32)
   // ---------------------------------------------------------------
   logic stall_evt;
   logic bubble_evt;

   assign stall_evt  = stall && !flush;
   assign bubble_evt = flush || (!stall && !id_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_evt) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (bubble_evt) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_shift_reg.sv
module tb_id_ex_shift_reg;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_shamt;
   logic        id_shamt_var;
   logic [1:0]  id_shifter_select;
   logic [3:0]  id_alu_ctrl;
   logic [4:0]  id_dest_reg;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_mem_to_reg;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_imm;
   logic [31:0] ex_shift_in;
   logic [4:0]  ex_shamt;
   logic [1:0]  ex_shifter_select;
   logic [3:0]  ex_alu_ctrl;
   logic [4:0]  ex_dest_reg;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_to_reg;
   logic        load_use_hazard;
`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   id_ex_shift_reg dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall             (stall),
      .flush             (flush),
      .id_valid          (id_valid),
      .id_pc             (id_pc),
      .id_rs_addr        (id_rs_addr),
      .id_rt_addr        (id_rt_addr),
      .id_rs_data        (id_rs_data),
      .id_rt_data        (id_rt_data),
      .id_imm            (id_imm),
      .id_shamt          (id_shamt),
      .id_shamt_var      (id_shamt_var),
      .id_shifter_select (id_shifter_select),
      .id_alu_ctrl       (id_alu_ctrl),
      .id_dest_reg       (id_dest_reg),
      .id_reg_write      (id_reg_write),
      .id_mem_read       (id_mem_read),
      .id_mem_write      (id_mem_write),
      .id_mem_to_reg     (id_mem_to_reg),
      .ex_valid          (ex_valid),
      .ex_pc             (ex_pc),
      .ex_rs_data        (ex_rs_data),
      .ex_rt_data        (ex_rt_data),
      .ex_imm            (ex_imm),
      .ex_shift_in       (ex_shift_in),
      .ex_shamt          (ex_shamt),
      .ex_shifter_select (ex_shifter_select),
      .ex_alu_ctrl       (ex_alu_ctrl),
      .ex_dest_reg       (ex_dest_reg),
      .ex_reg_write      (ex_reg_write),
      .ex_mem_read       (ex_mem_read),
      .ex_mem_write      (ex_mem_write),
      .ex_mem_to_reg     (ex_mem_to_reg),
`ifdef ID_EX_PERF_EN
      .stall_cnt         (stall_cnt),
      .bubble_cnt        (bubble_cnt),
`endif
      .load_use_hazard   (load_use_hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  shamt;
      logic        shamt_var;
      logic [1:0]  sel;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        reg_write;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [4:0]  exp_shamt;
      logic [31:0] exp_shift_in;
      logic [1:0]  exp_sel;
      logic        exp_reg_write;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_idle();
      stall             = 1'b0;
      flush             = 1'b0;
      id_valid          = 1'b0;
      id_pc             = '0;
      id_rs_addr        = '0;
      id_rt_addr        = '0;
      id_rs_data        = '0;
      id_rt_data        = '0;
      id_imm            = '0;
      id_shamt          = '0;
      id_shamt_var      = 1'b0;
      id_shifter_select = '0;
      id_alu_ctrl       = '0;
      id_dest_reg       = '0;
      id_reg_write      = 1'b0;
      id_mem_read       = 1'b0;
      id_mem_write      = 1'b0;
      id_mem_to_reg     = 1'b0;
   endtask

   task automatic drive_lw(input logic [31:0] pc, input logic [4:0] dest, input logic mem_read);
      id_idle();
      id_valid      = 1'b1;
      id_pc         = pc;
      id_dest_reg   = dest;
      id_mem_read   = mem_read;
      id_mem_to_reg = mem_read;
      id_reg_write  = 1'b1;
      id_alu_ctrl   = 4'd2;
   endtask

`ifdef ID_EX_PERF_EN
   logic [31:0] s0;
   logic [31:0] b0;
`endif

   initial begin
      //            valid pc           sh  var sel rs            rt            rw  e_v e_pc         e_sh e_shin        e_sel e_rw
      vecs[0] = '{1'b1, 32'h0000_0100, 5'd4,  1'b0, 2'd1, 32'h0000_0000, 32'h0000_000F, 1'b1, 1'b1, 32'h0000_0100, 5'd4,  32'h0000_000F, 2'd1, 1'b1};
      vecs[1] = '{1'b1, 32'h0000_0104, 5'd9,  1'b1, 2'd3, 32'h0000_0125, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0104, 5'd5,  32'h8000_0000, 2'd3, 1'b1};
      vecs[2] = '{1'b1, 32'h0000_0108, 5'd0,  1'b1, 2'd2, 32'h0000_0025, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0108, 5'd5,  32'h1234_5678, 2'd2, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_010C, 5'd7,  1'b0, 2'd2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0000, 5'd0,  32'h0000_0000, 2'd0, 1'b0};
      vecs[4] = '{1'b1, 32'h0000_0110, 5'd0,  1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0110, 5'd31, 32'h0000_0001, 2'd1, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0114, 5'd31, 1'b0, 2'd2, 32'h0000_0003, 32'hF000_0000, 1'b1, 1'b1, 32'h0000_0114, 5'd31, 32'hF000_0000, 2'd2, 1'b1};

      id_idle();
      rst_n = 1'b0;
      #2;
      check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("reset_ex_pc", ex_pc, 32'd0);
      #10 rst_n = 1'b1;
      step();

      // Table-driven captures
      for (int i = 0; i < 6; i++) begin
         id_idle();
         id_valid          = vecs[i].valid;
         id_pc             = vecs[i].pc;
         id_shamt          = vecs[i].shamt;
         id_shamt_var      = vecs[i].shamt_var;
         id_shifter_select = vecs[i].sel;
         id_rs_data        = vecs[i].rs;
         id_rt_data        = vecs[i].rt;
         id_reg_write      = vecs[i].reg_write;
         step();
         check($sformatf("vec%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_pc", i), ex_pc, vecs[i].exp_pc);
         check($sformatf("vec%0d_shamt", i), {27'd0, ex_shamt}, {27'd0, vecs[i].exp_shamt});
         check($sformatf("vec%0d_shift_in", i), ex_shift_in, vecs[i].exp_shift_in);
         check($sformatf("vec%0d_sel", i), {30'd0, ex_shifter_select}, {30'd0, vecs[i].exp_sel});
         check($sformatf("vec%0d_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].exp_reg_write});
      end

      // Async reset mid-cycle during a stall, then normal load after release
      drive_lw(32'h0000_0400, 5'd8, 1'b1);
      step();
      check("rst_pre_valid", {31'd0, ex_valid}, 32'd1);
      id_rs_addr = 5'd8;
      stall      = 1'b1;
      #1;
      check("rst_pre_hazard", {31'd0, load_use_hazard}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_async_pc", ex_pc, 32'd0);
      check("rst_async_mem_read", {31'd0, ex_mem_read}, 32'd0);
      check("rst_async_hazard", {31'd0, load_use_hazard}, 32'd0);
      #2 rst_n = 1'b1;
      stall = 1'b0;
      step();
      check("rst_release_valid", {31'd0, ex_valid}, 32'd1);
      check("rst_release_pc", ex_pc, 32'h0000_0400);

      // Stall two cycles then stall+flush
      id_idle();
      id_valid          = 1'b1;
      id_pc             = 32'h0000_0A00;
      id_alu_ctrl       = 4'd5;
      id_dest_reg       = 5'd3;
      id_reg_write      = 1'b1;
      id_shifter_select = 2'd1;
      id_shamt          = 5'd2;
      step();
`ifdef ID_EX_PERF_EN
      s0 = stall_cnt;
      b0 = bubble_cnt;
`endif
      id_pc       = 32'h0000_0B00;
      id_alu_ctrl = 4'd9;
      id_dest_reg = 5'd7;
      stall       = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         check($sformatf("stall%0d_pc", k), ex_pc, 32'h0000_0A00);
         check($sformatf("stall%0d_alu", k), {28'd0, ex_alu_ctrl}, 32'd5);
         check($sformatf("stall%0d_dest", k), {27'd0, ex_dest_reg}, 32'd3);
      end
      flush = 1'b1;
      step();
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      check("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
      check("flush_alu", {28'd0, ex_alu_ctrl}, 32'd0);
      check("flush_dest", {27'd0, ex_dest_reg}, 32'd0);
      check("flush_sel", {30'd0, ex_shifter_select}, 32'd0);
      check("flush_pc", ex_pc, 32'd0);
`ifdef ID_EX_PERF_EN
      check("perf_stall_cnt", stall_cnt - s0, 32'd2);
      check("perf_bubble_cnt", bubble_cnt - b0, 32'd1);
`endif

      // Load-use hazard
      drive_lw(32'h0000_0C00, 5'd8, 1'b1);
      step();
      id_idle();
      id_valid   = 1'b1;
      id_rs_addr = 5'd8;
      id_rt_addr = 5'd2;
      #1;
      check("lu_rs_match", {31'd0, load_use_hazard}, 32'd1);
      id_valid = 1'b0;
      #1;
      check("lu_id_invalid", {31'd0, load_use_hazard}, 32'd0);
      id_valid   = 1'b1;
      id_rs_addr = 5'd3;
      id_rt_addr = 5'd8;
      #1;
      check("lu_rt_match", {31'd0, load_use_hazard}, 32'd1);
      id_rs_addr = 5'd3;
      id_rt_addr = 5'd4;
      #1;
      check("lu_no_match", {31'd0, load_use_hazard}, 32'd0);
      id_rs_addr = 5'd8;
      stall      = 1'b1;
      step();
      check("lu_held_dest", {27'd0, ex_dest_reg}, 32'd8);
      check("lu_held_hazard", {31'd0, load_use_hazard}, 32'd1);
      drive_lw(32'h0000_0D00, 5'd0, 1'b1);
      step();
      id_idle();
      id_valid = 1'b1;
      #1;
      check("lu_dest_zero", {31'd0, load_use_hazard}, 32'd0);
      drive_lw(32'h0000_0E00, 5'd8, 1'b0);
      step();
      id_idle();
      id_valid   = 1'b1;
      id_rs_addr = 5'd8;
      #1;
      check("lu_not_load", {31'd0, load_use_hazard}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_shift_reg.md
Name: id_ex_shift_reg

Overview:
- ID/EX pipeline register feeding the execute stage, including the shifter: operand `in1`, `shamt`, and 2-bit `shifter_select`.
- Resolves the shift-amount source: immediate shamt field, or rs[4:0] for sllv/srlv/srav.
- Handles stall and flush. Bubbles are inserted with all side-effect controls zeroed.
- Flags load-use hazards for the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 5, register-file address width.
- ALU_CTRL_W, 4, ALU control code width.
- SHAMT_W, $clog2(DATA_W), shift-amount width (5 at default).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all EX-side registers.
- flush  in  1  replace EX contents with a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DATA_W  instruction PC.
- id_rs_addr, id_rt_addr  in  REG_ADDR_W  source register numbers.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_shamt  in  SHAMT_W  instruction shamt field.
- id_shamt_var  in  1  1 = variable shift; take shamt from id_rs_data[SHAMT_W-1:0].
- id_shifter_select  in  2  0 none, 1 sll, 2 srl, 3 sra.
- id_alu_ctrl  in  ALU_CTRL_W  ALU operation.
- id_dest_reg  in  REG_ADDR_W  writeback register.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  side-effect controls.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered copies.
- ex_shift_in  out  DATA_W  shifter in1 (= registered rt data).
- ex_shamt  out  SHAMT_W  resolved shift amount.
- ex_shifter_select  out  2  to shifter.
- ex_alu_ctrl, ex_dest_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  as above.
- load_use_hazard  out  1  combinational, to hazard unit.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, effective immediately, independent of clk.
- Per-edge priority: flush > stall > load.
  - Flush: bubble.
  - Stall (no flush): all outputs hold.
  - Otherwise: load from ID.
- Bubble: ex_valid=0; all side-effect controls, ex_shifter_select, ex_alu_ctrl, ex_dest_reg = 0; data fields = 0.
- Load with id_valid=0 is treated exactly as a bubble.
- Load with id_valid=1:
  - All fields are captured; ex_shift_in = id_rt_data.
  - ex_shamt = id_shamt_var ? id_rs_data[SHAMT_W-1:0] : id_shamt.
  - Shamt is resolved at capture, not in EX. Upper bits of rs are ignored (rs = 32'h25 → shamt 5).
- Latency: exactly 1 cycle from ID input to EX output.
- Guaranteed invariant: ex_shifter_select=0 whenever ex_valid=0, so a bubble yields shifter_result 0.
- load_use_hazard = ex_valid & ex_mem_read & (ex_dest_reg != 0) & id_valid & (ex_dest_reg == id_rs_addr | ex_dest_reg == id_rt_addr).
  - Register 0 never raises a hazard.
  - Hazard is evaluated on current outputs, so it stays asserted while stall holds EX.
- Stall and flush together: flush wins (branch-mispredict kill overrides a hazard hold).
- Reset asserted mid-stall: outputs clear; after release, the first edge loads normally.
- No internal state beyond the pipeline registers (and the counters below).

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds output ports stall_cnt and bubble_cnt, 32 bits each.
  - stall_cnt increments on each edge with stall=1 & flush=0.
  - bubble_cnt increments on each edge where a bubble is written (flush, or load with id_valid=0).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - typedef shift_sel_t (enum SH_NONE=0, SH_SLL=1, SH_SRL=2, SH_SRA=3).
  - ex_ctrl_t packed struct (alu_ctrl, shifter_select, reg_write, mem_read, mem_write, mem_to_reg, dest_reg).
  - constant EX_CTRL_BUBBLE = '0.
- One natural sub-module: hazard_detect_lu, the combinational load-use comparator, reused by the forwarding/hazard unit.

Test Plan:
- Reset: rst_n low mid-cycle with ex_valid=1 → all outputs 0 immediately; load_use_hazard=0.
- Immediate shift: id_valid=1, shifter_select=1, id_shamt=4, shamt_var=0, rt=32'h0000_000F → next cycle ex_shamt=4, ex_shift_in=32'h0F, ex_shifter_select=1, ex_valid=1.
- Variable shift: shamt_var=1, rs=32'h0000_0125, shifter_select=3 → ex_shamt=5, ex_shifter_select=3.
- Stall then flush: capture instr A; stall 2 cycles while ID changes → outputs hold A; assert stall+flush together → bubble (ex_valid=0, all controls 0). With ID_EX_PERF_EN: stall_cnt=2, bubble_cnt=1.
- Load-use: EX holds lw with dest=8, mem_read=1; ID id_valid=1 with rs_addr=8 → load_use_hazard=1. Same with dest=0 → 0. Same with id_valid=0 → 0.
- Invalid capture: id_valid=0 with id_reg_write=1, id_shifter_select=2 → ex_reg_write=0, ex_shifter_select=0, ex_valid=0.
